// File: rtl/checkers_pkg.sv
// Shared types and defaults for the checkers bitboard move generator.
package checkers_pkg;

    localparam int unsigned ROWS_DEF = 8;
    localparam int unsigned W_DEF    = 4;

    typedef enum logic [1:0] {
        DIR_UL = 2'd0,
        DIR_UR = 2'd1,
        DIR_DL = 2'd2,
        DIR_DR = 2'd3
    } dir_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/bb_shift.sv
// Combinational one-square diagonal shift of a dark-square bitboard.
module bb_shift
    import checkers_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic [1:0]          dir,
    input  logic [ROWS*W-1:0]   src,
    output logic [ROWS*W-1:0]   dst
);

    localparam int unsigned N  = ROWS * W;
    localparam int          NI = int'(N);
    localparam int          WI = int'(W);

    // Squares on rows of the given parity, optionally excluding one slot (skip < 0 keeps all).
    function automatic logic [N-1:0] row_mask(input int parity, input int skip);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < NI; i++) begin
            if (((i / WI) % 2) == parity && (i % WI) != skip) begin
                m = m | (N'(1) << i);
            end
        end
        return m;
    endfunction

    localparam logic [N-1:0] M_EVEN   = row_mask(0, -1);
    localparam logic [N-1:0] M_EVEN_L = row_mask(0, 0);
    localparam logic [N-1:0] M_ODD    = row_mask(1, -1);
    localparam logic [N-1:0] M_ODD_R  = row_mask(1, WI - 1);

    // Off-board moves fall off the vector ends; edge columns are masked before shifting.
    always_comb begin
        dst = '0;
        case (dir)
            DIR_UL:  dst = ((src & M_EVEN_L) >> (W + 1)) | ((src & M_ODD)   >> W);
            DIR_UR:  dst = ((src & M_EVEN)   >> W)       | ((src & M_ODD_R) >> (W - 1));
            DIR_DL:  dst = ((src & M_EVEN_L) << (W - 1)) | ((src & M_ODD)   << W);
            DIR_DR:  dst = ((src & M_EVEN)   << W)       | ((src & M_ODD_R) << (W + 1));
            default: dst = '0;
        endcase
    end

endmodule

// File: rtl/bb_move_gen.sv
// Latches a board and streams per-direction step and capture masks as four handshaked beats.
module bb_move_gen
    import checkers_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ROWS*W-1:0]   own,
    input  logic [ROWS*W-1:0]   opp,
    input  logic [ROWS*W-1:0]   kings,
    input  logic                side,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_dir,
    output logic [ROWS*W-1:0]   out_step,
    output logic [ROWS*W-1:0]   out_jump,
    output logic                out_last,
    output logic                out_jump_any
);

    localparam int unsigned N = ROWS * W;

    state_e         state_q, state_d;
    logic [N-1:0]   own_q, own_d, opp_q, opp_d, kings_q, kings_d;
    logic           side_q, side_d;
    logic [1:0]     dir_q, dir_d;
    logic           valid_q, valid_d;
    logic           acc_q, acc_d;
    logic           busy_q, busy_d;
    logic           last_q, last_d;
    logic           jany_q, jany_d;
    logic [N-1:0]   step_q, step_d, jump_q, jump_d;

    logic [N-1:0]   movers, empty, s_step, s_jump;

    // Control: accept a board in IDLE, advance one direction per handshake in EMIT.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        opp_d   = opp_q;
        kings_d = kings_q;
        side_d  = side_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EMIT;
                    own_d   = own;
                    opp_d   = opp;
                    kings_d = kings;
                    side_d  = side;
                    dir_d   = DIR_UL;
                    valid_d = 1'b1;
                    acc_d   = 1'b0;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    acc_d = acc_q | (|jump_q);
                    if (dir_q == DIR_DR) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        dir_d   = DIR_UL;
                    end else begin
                        dir_d = 2'(dir_q + 2'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Men only move forward; dir[1] set means a downward direction.
    always_comb begin
        movers = (dir_d[1] ^ side_d) ? own_d : (own_d & kings_d);
        empty  = ~(own_d | opp_d);
    end

    bb_shift #(.ROWS(ROWS), .W(W)) u_shift_step (
        .dir (dir_d),
        .src (movers),
        .dst (s_step)
    );

    bb_shift #(.ROWS(ROWS), .W(W)) u_shift_jump (
        .dir (dir_d),
        .src (s_step & opp_d),
        .dst (s_jump)
    );

    // Next beat payload, forced to zero whenever no beat is presented.
    always_comb begin
        step_d = valid_d ? (s_step & empty) : '0;
        jump_d = valid_d ? (s_jump & empty) : '0;
        last_d = valid_d && (dir_d == DIR_DR);
        jany_d = valid_d && (acc_d || (|jump_d));
        busy_d = (state_d == S_EMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            own_q   <= '0;
            opp_q   <= '0;
            kings_q <= '0;
            side_q  <= 1'b0;
            dir_q   <= '0;
            valid_q <= 1'b0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            jany_q  <= 1'b0;
            step_q  <= '0;
            jump_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            opp_q   <= opp_d;
            kings_q <= kings_d;
            side_q  <= side_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            jany_q  <= jany_d;
            step_q  <= step_d;
            jump_q  <= jump_d;
        end
    end

    assign busy         = busy_q;
    assign out_valid    = valid_q;
    assign out_dir      = dir_q;
    assign out_step     = step_q;
    assign out_jump     = jump_q;
    assign out_last     = last_q;
    assign out_jump_any = jany_q;

endmodule

// File: tb/tb_bb_move_gen.sv
// Randomized and directed checks of bb_move_gen against a row/column geometry model.
module tb_bb_move_gen;

    localparam int ROWS = 8;
    localparam int W    = 4;
    localparam int N    = ROWS * W;

    logic           clock = 1'b0;
    logic           reset, start, side, out_ready;
    logic [N-1:0]   own, opp, kings;
    logic           busy, out_valid, out_last, out_jump_any;
    logic [1:0]     out_dir;
    logic [N-1:0]   out_step, out_jump;

    int             compared = 0;
    int             mismatched = 0;
    int             cyc = 0;
    logic [N-1:0]   cap_step [4];
    logic [N-1:0]   cap_jump [4];
    logic           cap_any;

    bb_move_gen #(.ROWS(ROWS), .W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .own          (own),
        .opp          (opp),
        .kings        (kings),
        .side         (side),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dir      (out_dir),
        .out_step     (out_step),
        .out_jump     (out_jump),
        .out_last     (out_last),
        .out_jump_any (out_jump_any)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Move each piece one diagonal square using board row/column coordinates.
    function automatic logic [N-1:0] mshift(input logic [N-1:0] src, input int d);
        logic [N-1:0] res;
        int r, col, nr, nc, dr, dc;
        res = '0;
        dr = (d >= 2) ? 1 : -1;
        dc = (d % 2 == 1) ? 1 : -1;
        for (int i = 0; i < N; i++) begin
            if (((src >> i) & N'(1)) != '0) begin
                r   = i / W;
                col = (r % 2 == 0) ? 2 * (i % W) : 2 * (i % W) + 1;
                nr  = r + dr;
                nc  = col + dc;
                if (nr >= 0 && nr < ROWS && nc >= 0 && nc < 2 * W)
                    res = res | (N'(1) << (nr * W + nc / 2));
            end
        end
        return res;
    endfunction

    task automatic scramble();
        own   = $urandom;
        opp   = $urandom;
        kings = $urandom;
        side  = 1'($urandom);
        start = 1'($urandom);
    endtask

    task automatic run_board(input logic [N-1:0] b_own, input logic [N-1:0] b_opp,
                             input logic [N-1:0] b_kings, input logic b_side,
                             input int max_stall, input int first_stall, input int abort_at);
        logic [N-1:0] mv, emp, sh, es [4], ej [4];
        logic any;
        int stall, c0;
        any = 1'b0;
        emp = ~(b_own | b_opp);
        for (int d = 0; d < 4; d++) begin
            mv    = (((d >= 2) ? 1'b1 : 1'b0) != b_side) ? b_own : (b_own & b_kings);
            sh    = mshift(mv, d);
            es[d] = sh & emp;
            ej[d] = mshift(sh & b_opp, d) & emp;
            if (ej[d] != '0) any = 1'b1;
        end
        own = b_own; opp = b_opp; kings = b_kings; side = b_side;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        chk("accept_valid", 64'(out_valid), 64'd1);
        for (int d = 0; d < 4; d++) begin
            if (d == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("rst_valid", 64'(out_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_dir", 64'(out_dir), 64'd0);
                chk("rst_last", 64'(out_last), 64'd0);
                chk("rst_jany", 64'(out_jump_any), 64'd0);
                chk("rst_step", 64'(out_step), 64'd0);
                chk("rst_jump", 64'(out_jump), 64'd0);
                return;
            end
            stall = (d == 0 && first_stall > 0) ? first_stall : int'($urandom_range(max_stall, 0));
            out_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                scramble();
                tick();
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_dir", 64'(out_dir), 64'(d));
                chk("hold_step", 64'(out_step), 64'(es[d]));
                chk("hold_jump", 64'(out_jump), 64'(ej[d]));
            end
            scramble();
            out_ready = 1'b1;
            chk("beat_valid", 64'(out_valid), 64'd1);
            chk("beat_busy", 64'(busy), 64'd1);
            chk("beat_dir", 64'(out_dir), 64'(d));
            chk("beat_step", 64'(out_step), 64'(es[d]));
            chk("beat_jump", 64'(out_jump), 64'(ej[d]));
            chk("beat_last", 64'(out_last), 64'(d == 3));
            if (d == 3) chk("jump_any", 64'(out_jump_any), 64'(any));
            cap_step[d] = out_step;
            cap_jump[d] = out_jump;
            if (d == 3) cap_any = out_jump_any;
            tick();
        end
        out_ready = 1'b0;
        start = 1'b0;
        if (max_stall == 0 && first_stall == 0)
            chk("latency", 64'(cyc - c0), 64'd4);
        chk("end_valid", 64'(out_valid), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_step", 64'(out_step), 64'd0);
        chk("end_jump", 64'(out_jump), 64'd0);
        chk("end_last", 64'(out_last), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        own = '0; opp = '0; kings = '0; side = 1'b0;
        tick();
        tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_step", 64'(out_step), 64'd0);
        chk("reset_jany", 64'(out_jump_any), 64'd0);
        reset = 1'b0;
        tick();

        // Lone man on square 9.
        run_board(32'h200, 32'h0, 32'h0, 1'b0, 0, 0, 4);
        chk("sq9_ul", 64'(cap_step[0]), 64'h0);
        chk("sq9_ur", 64'(cap_step[1]), 64'h0);
        chk("sq9_dl", 64'(cap_step[2]), 64'h1000);
        chk("sq9_dr", 64'(cap_step[3]), 64'h2000);
        chk("sq9_any", 64'(cap_any), 64'd0);

        // Capture available down-right.
        run_board(32'h200, 32'h2000, 32'h0, 1'b0, 0, 0, 4);
        chk("cap_dr_step", 64'(cap_step[3]), 64'h0);
        chk("cap_dr_jump", 64'(cap_jump[3]), 64'h40000);
        chk("cap_dl_step", 64'(cap_step[2]), 64'h1000);
        chk("cap_any", 64'(cap_any), 64'd1);

        // Edge blocking on squares 0 and 7.
        run_board(32'h81, 32'h0, 32'h0, 1'b0, 0, 0, 4);
        chk("edge_dl", 64'(cap_step[2]), 64'h800);
        chk("edge_dr", 64'(cap_step[3]), 64'h10);

        // King moves in all directions; man with side=1 moves up only.
        run_board(32'h200, 32'h0, 32'h200, 1'b0, 0, 0, 4);
        chk("king_ul", 64'(cap_step[0]), 64'h10);
        chk("king_ur", 64'(cap_step[1]), 64'h20);
        chk("king_dl", 64'(cap_step[2]), 64'h1000);
        chk("king_dr", 64'(cap_step[3]), 64'h2000);
        run_board(32'h200, 32'h0, 32'h0, 1'b1, 0, 0, 4);
        chk("up_ul", 64'(cap_step[0]), 64'h10);
        chk("up_ur", 64'(cap_step[1]), 64'h20);
        chk("up_dl", 64'(cap_step[2]), 64'h0);
        chk("up_dr", 64'(cap_step[3]), 64'h0);

        // Five-cycle backpressure on the first beat.
        run_board(32'h200, 32'h2000, 32'h200, 1'b0, 0, 5, 4);

        // Reset after the beat-1 handshake, then a clean restart.
        run_board(32'h200, 32'h2000, 32'h0, 1'b0, 0, 0, 2);
        tick();
        run_board(32'h81, 32'h2000, 32'h81, 1'b1, 0, 0, 4);

        for (int n = 0; n < 40; n++) begin
            logic [N-1:0] ro, rp;
            ro = $urandom;
            rp = $urandom & ~ro;
            run_board(ro, rp, $urandom, 1'($urandom), 2, 0, 4);
            if ($urandom_range(1, 0) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
